// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the byte-organised instruction memory
// and the loader that fills it.
package mips_mem_pkg;
   localparam int unsigned ADDR_W         = 10;
   localparam int unsigned MEM_BYTES      = 1024;
   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WAIT_WORD,
      WRITE,
      FINISH
   } loader_state_t;
endpackage

// File: rtl/instruction_loader.sv
// Streams 32-bit instruction words into byte-wide instruction memory,
// little-endian, one byte write per cycle; all outputs registered.
module instruction_loader #(
   parameter int unsigned ADDR_W    = mips_mem_pkg::ADDR_W,
   parameter int unsigned MEM_BYTES = mips_mem_pkg::MEM_BYTES,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_word,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error
);
   import mips_mem_pkg::*;

   localparam int unsigned EXT_W = 32 + CNT_W + 2;

   loader_state_t     state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        idx_q, idx_d;
   logic              error_d;
   logic [EXT_W-1:0]  end_addr;

   logic              in_ready_d, mem_we_d, busy_d, done_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [7:0]        mem_wdata_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         word_q   <= '0;
         idx_q    <= '0;
         error    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         word_q   <= word_d;
         idx_q    <= idx_d;
         error    <= error_d;
      end
   end

   // Extended width so a base near 2^32 cannot wrap past the range check.
   always_comb begin
      end_addr = EXT_W'(addr_q) + EXT_W'(remain_q) * EXT_W'(BYTES_PER_WORD);
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      word_d   = word_q;
      idx_d    = idx_q;
      error_d  = error;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               remain_d = word_count;
               error_d  = 1'b0;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            if (remain_q == '0) begin
               state_d = FINISH;
            end else if (addr_q[1:0] != 2'b00) begin
               error_d = 1'b1;
               state_d = FINISH;
            end else if (end_addr > EXT_W'(MEM_BYTES)) begin
               error_d = 1'b1;
               state_d = FINISH;
            end else begin
               state_d = WAIT_WORD;
            end
         end
         WAIT_WORD: begin
            if (in_valid && in_ready) begin
               word_d  = in_word;
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
               idx_d    = '0;
               addr_d   = addr_q + 32'(BYTES_PER_WORD);
               remain_d = remain_q - CNT_W'(1);
               state_d  = (remain_q == CNT_W'(1)) ? FINISH : WAIT_WORD;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so the registers line up
   // with the state they describe.
   always_comb begin
      in_ready_d  = (state_d == WAIT_WORD);
      mem_we_d    = (state_d == WRITE);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FINISH) && !error_d;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (mem_we_d) begin
         mem_addr_d  = addr_d[ADDR_W-1:0] + ADDR_W'(idx_d);
         mem_wdata_d = word_d[{idx_d, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         in_ready  <= in_ready_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus
// randomized loads checked against a byte-level reference model.
module tb_instruction_loader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic        in_valid;
   logic [31:0] in_word;
   logic        in_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        busy;
   logic        done;
   logic        error;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   logic [7:0]  tmem [0:1023];
   int unsigned log_a [$];
   logic [7:0]  log_d [$];
   logic [31:0] ld_words [$];

   instruction_loader #(.ADDR_W(10), .MEM_BYTES(1024), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .in_valid(in_valid), .in_word(in_word),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         tmem[mem_addr] = mem_wdata;
         log_a.push_back(int'(mem_addr));
         log_d.push_back(mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one load of ld_words; the model derives every expectation from
   // base/count alone.
   task automatic do_load(input string name, input logic [31:0] base, input int unsigned cnt,
                          input int unsigned first_stall, input int unsigned stall_max,
                          input bit poke_start);
      int unsigned exp_a [$];
      logic [7:0]  exp_d [$];
      bit          exp_err;
      longint unsigned endv;
      int unsigned idx, done_cnt, busy_cyc, stall, nmin;
      bit          ready_prev, finished, poked;

      endv    = 64'(base) + 64'(cnt) * 4;
      exp_err = (cnt != 0) && ((base % 4) != 0 || endv > 1024);
      if (cnt != 0 && !exp_err)
         for (int unsigned i = 0; i < cnt; i++)
            for (int unsigned k = 0; k < 4; k++) begin
               exp_a.push_back(base + 4 * i + k);
               exp_d.push_back(8'((ld_words[i] >> (8 * k)) & 32'hFF));
            end
      log_a.delete();
      log_d.delete();

      @(negedge clk);
      start = 1'b1; base_addr = base; word_count = 16'(cnt);
      @(negedge clk);
      start = 1'b0;
      idx = 0; done_cnt = 0; busy_cyc = 0; stall = first_stall;
      ready_prev = 1'b0; finished = 1'b0; poked = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (in_valid && ready_prev) begin
            idx++;
            in_valid = 1'b0;
         end
         if (busy) busy_cyc++;
         if (done) done_cnt++;
         if (in_ready && mem_we) chk({name, ".ready_during_write"}, 1, 0);
         if (!busy) begin
            finished = 1'b1;
            break;
         end
         if (poke_start && mem_we && !poked) begin
            start = 1'b1; base_addr = base + 64; word_count = 16'(cnt + 1);
            poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (!in_valid && idx < cnt) begin
            if (stall > 0) stall--;
            else begin
               in_valid = 1'b1;
               in_word  = ld_words[idx];
               stall    = $urandom_range(stall_max, 0);
            end
         end
         ready_prev = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk({name, ".finished"}, finished, 1);
      chk({name, ".error"}, error, exp_err);
      chk({name, ".done_pulses"}, done_cnt, exp_err ? 0 : 1);
      chk({name, ".words_taken"}, idx, (exp_err || cnt == 0) ? 0 : cnt);
      if (first_stall == 0 && stall_max == 0)
         chk({name, ".busy_cycles"}, busy_cyc, (exp_err || cnt == 0) ? 2 : 2 + 5 * cnt);
      chk({name, ".nwrites"}, log_a.size(), exp_a.size());
      nmin = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
      for (int unsigned i = 0; i < nmin; i++) begin
         chk($sformatf("%s.waddr[%0d]", name, i), log_a[i], exp_a[i]);
         chk($sformatf("%s.wdata[%0d]", name, i), log_d[i], exp_d[i]);
      end
      if (poke_start) begin
         repeat (3) @(negedge clk);
         chk({name, ".ignored_start_idle"}, busy, 0);
      end
   endtask

   initial begin
      bit found;
      logic [31:0] b;
      int unsigned cnt, mode;

      rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
      in_valid = 1'b0; in_word = '0;
      for (int i = 0; i < 1024; i++) tmem[i] = 8'h00;
      #1;
      chk("rst.in_ready", in_ready, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.error", error, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      ld_words = '{32'h8C010004, 32'h00221820};
      do_load("basic", 32'd0, 2, 0, 0, 1'b0);
      chk("basic.fetch0", {tmem[3], tmem[2], tmem[1], tmem[0]}, 32'h8C010004);
      chk("basic.fetch4", {tmem[7], tmem[6], tmem[5], tmem[4]}, 32'h00221820);

      ld_words = '{32'hDEADBEEF, 32'h12345678};
      do_load("backpressure", 32'd8, 2, 9, 0, 1'b0);

      ld_words = '{32'hCAFEF00D};
      do_load("top_ok", 32'd1020, 1, 0, 0, 1'b0);
      chk("top_ok.fetch", {tmem[1023], tmem[1022], tmem[1021], tmem[1020]}, 32'hCAFEF00D);
      ld_words = '{32'h11111111, 32'h22222222};
      do_load("top_over", 32'd1020, 2, 0, 0, 1'b0);

      ld_words = '{32'h33333333};
      do_load("misaligned", 32'd6, 1, 0, 0, 1'b0);
      repeat (2) @(negedge clk);
      chk("misaligned.sticky", error, 1);
      ld_words.delete();
      do_load("zero_count", 32'd0, 0, 0, 0, 1'b0);

      ld_words = '{32'hFFFFFFFF};
      do_load("wrap", 32'hFFFF_FFFC, 1, 0, 0, 1'b0);

      ld_words = '{32'hA5A55A5A, 32'h0F0F7788};
      do_load("start_busy", 32'd32, 2, 0, 0, 1'b1);

      // Reset mid-write: abort on byte 1 of the word at 16.
      ld_words.delete();
      log_a.delete(); log_d.delete();
      tmem[18] = 8'h00; tmem[19] = 8'h00;
      @(negedge clk);
      start = 1'b1; base_addr = 32'd16; word_count = 16'd1;
      in_valid = 1'b1; in_word = 32'hA1B2C3D4;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (mem_we && mem_addr == 10'd17) begin
            found = 1'b1;
            break;
         end
         if (in_ready) ;
         @(negedge clk);
         if (mem_we) in_valid = 1'b0;
      end
      chk("rstmid.reached_k1", found, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid.in_ready", in_ready, 0);
      chk("rstmid.mem_we", mem_we, 0);
      chk("rstmid.mem_addr", mem_addr, 0);
      chk("rstmid.mem_wdata", mem_wdata, 0);
      chk("rstmid.busy", busy, 0);
      chk("rstmid.done", done, 0);
      chk("rstmid.error", error, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rstmid.nwrites", log_a.size(), 2);
      chk("rstmid.byte16", tmem[16], 8'hD4);
      chk("rstmid.byte17", tmem[17], 8'hC3);
      chk("rstmid.byte18", tmem[18], 8'h00);
      chk("rstmid.byte19", tmem[19], 8'h00);
      chk("rstmid.idle_busy", busy, 0);
      ld_words = '{32'h0BADF00D};
      do_load("after_rst", 32'd16, 1, 0, 0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         mode = $urandom_range(3, 0);
         cnt  = $urandom_range(4, 1);
         unique case (mode)
            0: b = 4 * $urandom_range(256 - cnt, 0);
            1: b = 4 * $urandom_range(200, 0) + $urandom_range(3, 1);
            2: begin
               cnt = $urandom_range(4, 2);
               b   = 4 * (256 - cnt + $urandom_range(cnt - 1, 1));
            end
            default: begin
               cnt = 0;
               b   = $urandom;
            end
         endcase
         ld_words.delete();
         for (int unsigned i = 0; i < cnt; i++) ld_words.push_back($urandom);
         do_load($sformatf("rand%0d", t), b, cnt, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
